multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
- REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: number of unacknowledged request cycles before a bus timeout; used only with CTRL_TIMEOUT_EN.
- REQ-002 SHALL have port clk_i, input, 1 bit: the only clock; all state changes on its rising edge.
- REQ-003 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
- REQ-004 SHALL have port instr_i, input, 32 bits: instruction register contents, also feeding the immediate generator.
- REQ-005 SHALL have port imem_req_o, output, 1 bit: instruction fetch request.
- REQ-006 SHALL have port imem_ack_i, input, 1 bit: instruction fetch acknowledge.
- REQ-007 SHALL have ports dmem_req_o and dmem_we_o, outputs, 1 bit each: data access request and write flag.
- REQ-008 SHALL have port dmem_ack_i, input, 1 bit: data access acknowledge.
- REQ-009 SHALL have port br_taken_i, input, 1 bit: branch comparator result.
- REQ-010 SHALL have ports ir_we_o, pc_we_o and rf_we_o, outputs, 1 bit each: instruction register, PC and register-file write enables.
- REQ-011 SHALL have port pc_sel_o, output, 1 bit: 0 selects PC+4, 1 selects the registered ALU result.
- REQ-012 SHALL have port alu_a_sel_o, output, 2 bits: 00 rs1, 01 PC, 10 zero.
- REQ-013 SHALL have port alu_b_sel_o, output, 1 bit: 0 rs2, 1 immediate.
- REQ-014 SHALL have port wb_sel_o, output, 2 bits: 00 ALU, 01 memory, 10 PC+4.
- REQ-015 SHALL have ports illegal_o and timeout_o, outputs, 1 bit each; plus state_o, output, 3 bits: current state code.

Function
- REQ-016 SHALL use state codes FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and TRAP=5; opcode is instr_i[6:2]; instr_i is ignored in FETCH.
- REQ-017 SHALL treat as legal only instr_i[1:0]=11 with opcode in {01101 LUI, 00101 AUIPC, 11011 JAL, 11001 JALR, 11000 BRANCH, 00000 LOAD, 01000 STORE, 00100 OP-IMM, 01100 OP}.
- REQ-018 FETCH SHALL hold imem_req_o=1 until imem_ack_i=1, pulse ir_we_o in the ack cycle, then go to DECODE; an ack arriving while req=0 SHALL be ignored.
- REQ-019 DECODE SHALL go to TRAP if the instruction is illegal, otherwise to EXEC, asserting no write enables.
- REQ-020 EXEC SHALL drive alu_a_sel_o=01 for AUIPC, JAL and BRANCH, 10 for LUI, 00 otherwise, and alu_b_sel_o=0 only for OP.
- REQ-021 In EXEC, LOAD and STORE SHALL go to MEM, BRANCH SHALL pulse pc_we_o with pc_sel_o=br_taken_i and go to FETCH, and all other instructions SHALL go to WB.
- REQ-022 MEM SHALL hold dmem_req_o=1 (dmem_we_o=1 for STORE) until dmem_ack_i; on ack, STORE SHALL pulse pc_we_o (pc_sel_o=0) and go to FETCH, and LOAD SHALL go to WB.
- REQ-023 WB SHALL pulse rf_we_o with wb_sel_o=01 for LOAD, 10 for JAL/JALR, 00 otherwise.
- REQ-024 WB SHALL pulse pc_we_o with pc_sel_o=1 for JAL/JALR and 0 otherwise, then go to FETCH.
- REQ-025 TRAP SHALL hold illegal_o=1 and all enables/requests at 0 until reset; it is the only sink state.
- REQ-026 Each enable SHALL be high for exactly one cycle per instruction, with no enable active in the same cycle as another state's enable.

Reset
- REQ-027 While rst_i=1, state SHALL be FETCH and every output SHALL be 0 (state_o=0), independent of clk_i.
- REQ-028 imem_req_o SHALL first assert in the first cycle after rst_i deasserts; reset during any state SHALL abort the access with no further enables.

Configuration
- REQ-029 With CTRL_TIMEOUT_EN defined, a counter cleared on entry to FETCH/MEM SHALL count unacknowledged request cycles; if no ack arrives within TIMEOUT_CYCLES cycles, the controller SHALL enter TRAP with timeout_o=1 (illegal_o=0).
- REQ-030 Without CTRL_TIMEOUT_EN, the controller SHALL wait indefinitely and timeout_o SHALL be tied to 0.

Verification
- REQ-031 Reset, instr 0x00500093 (ADDI), imem ack 2 cycles after req -> ir_we_o in ack cycle; then DECODE, EXEC (alu_b_sel_o=1), WB with rf_we_o=1, wb_sel_o=00, pc_we_o=1, pc_sel_o=0.
- REQ-032 0x0000A103 (LW), dmem_ack_i on 3rd MEM cycle -> dmem_req_o high 3 cycles, dmem_we_o=0, then WB with wb_sel_o=01.
- REQ-033 0x00112023 (SW), immediate acks -> dmem_we_o=1 in MEM, pc_we_o in MEM ack cycle, no rf_we_o, FETCH next; 4 cycles total.
- REQ-034 0x00000463 (BEQ): with br_taken_i=1 -> EXEC pc_we_o=1, pc_sel_o=1; with br_taken_i=0 -> pc_sel_o=0; next state is FETCH in both cases.
- REQ-035 0x008000EF (JAL) -> EXEC alu_a_sel_o=01; WB wb_sel_o=10, pc_sel_o=1.
- REQ-036 0x00000000 -> TRAP, illegal_o=1 held for 20 cycles until rst_i; with CTRL_TIMEOUT_EN, imem_ack_i held low for 16 cycles -> TRAP, timeout_o=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for a multicycle RV32I-style datapath. Sequences each
// instruction through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH and
// produces the one-cycle write enables, the memory requests and the datapath
// mux selects. Illegal instructions park the controller in TRAP until reset.
//
// Optional feature (macro CTRL_TIMEOUT_EN):
//   When defined, a FETCH or MEM request left unacknowledged for
//   TIMEOUT_CYCLES cycles sends the controller to TRAP with timeout_o=1.
//   When undefined, requests wait indefinitely and timeout_o is tied low.
//
// Parameters
//   TIMEOUT_CYCLES  unacknowledged request cycles before a bus timeout
//
// Ports
//   clk_i           clock, all state changes on its rising edge
//   rst_i           asynchronous active-high reset; forces every output low
//   instr_i         instruction register contents (ignored in FETCH)
//   imem_req_o      instruction fetch request
//   imem_ack_i      instruction fetch acknowledge
//   dmem_req_o      data access request
//   dmem_we_o       data access write flag
//   dmem_ack_i      data access acknowledge
//   br_taken_i      branch comparator result
//   ir_we_o         instruction register write enable
//   pc_we_o         PC write enable
//   rf_we_o         register file write enable
//   pc_sel_o        0: PC+4, 1: registered ALU result
//   alu_a_sel_o     00: rs1, 01: PC, 10: zero
//   alu_b_sel_o     0: rs2, 1: immediate
//   wb_sel_o        00: ALU, 01: memory, 10: PC+4
//   illegal_o       held high in TRAP entered on an illegal instruction
//   timeout_o       held high in TRAP entered on a bus timeout
//   state_o         current state code
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    input  logic        br_taken_i,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        rf_we_o,
    output logic        pc_sel_o,
    output logic [1:0]  alu_a_sel_o,
    output logic        alu_b_sel_o,
    output logic [1:0]  wb_sel_o,
    output logic        illegal_o,
    output logic        timeout_o,
    output logic [2:0]  state_o
);

    // -------------------------------------------------------------------------
    // Types and constants
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;

    localparam logic [1:0] ALU_A_RS1  = 2'b00;
    localparam logic [1:0] ALU_A_PC   = 2'b01;
    localparam logic [1:0] ALU_A_ZERO = 2'b10;

    localparam logic [1:0] WB_ALU     = 2'b00;
    localparam logic [1:0] WB_MEM     = 2'b01;
    localparam logic [1:0] WB_PC4     = 2'b10;

    // Every controller output in one bundle so reset gating is a single mux.
    typedef struct packed {
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic       pc_sel;
        logic       rf_we;
        logic [1:0] alu_a_sel;
        logic       alu_b_sel;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       timeout;
    } ctrl_t;

    // -------------------------------------------------------------------------
    // Instruction decode (only meaningful outside FETCH)
    // -------------------------------------------------------------------------
    logic [4:0] opcode;
    logic       is_lui;
    logic       is_auipc;
    logic       is_jal;
    logic       is_jalr;
    logic       is_branch;
    logic       is_load;
    logic       is_store;
    logic       is_opimm;
    logic       is_op;
    logic       legal;

    assign opcode    = instr_i[6:2];
    assign is_lui    = (opcode == OPC_LUI);
    assign is_auipc  = (opcode == OPC_AUIPC);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_jalr   = (opcode == OPC_JALR);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_op     = (opcode == OPC_OP);

    // Compressed encodings (instr_i[1:0] != 11) are not supported.
    assign legal = (instr_i[1:0] == 2'b11) &&
                   (is_lui | is_auipc | is_jal | is_jalr | is_branch |
                    is_load | is_store | is_opimm | is_op);

    // The remaining instruction fields belong to the datapath.
    logic unused_instr;
    assign unused_instr = ^instr_i[31:7];

    // -------------------------------------------------------------------------
    // State register and optional request timeout
    // -------------------------------------------------------------------------
    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;
    logic   wait_expired;   // current request has run out of cycles
    logic   timeout_entry;  // this cycle moves to TRAP because of a timeout
    logic   trap_by_timeout;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
    // takes effect without waiting for a clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef CTRL_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    // The counter holds the number of request cycles already spent without
    // an ack; it restarts whenever the state changes (entry to FETCH/MEM).
    always_comb begin
        wait_cnt_d = '0;
        if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        timeout_d = timeout_q | timeout_entry;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // The cycle in which the count reaches TIMEOUT_CYCLES-1 is the last one
    // an ack may still arrive in.
    assign wait_expired    = (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign trap_by_timeout = timeout_q;
`else
    assign wait_expired    = 1'b0;
    assign trap_by_timeout = 1'b0;

    logic unused_timeout;
    assign unused_timeout = timeout_entry ^ (TIMEOUT_CYCLES != 0);
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d       = state_q;
        timeout_entry = 1'b0;
        ctrl          = '0;

        unique case (state_q)
            S_FETCH: begin
                ctrl.imem_req = 1'b1;
                if (imem_ack_i) begin
                    ctrl.ir_we = 1'b1;
                    state_d    = S_DECODE;
                end else if (wait_expired) begin
                    timeout_entry = 1'b1;
                    state_d       = S_TRAP;
                end
            end

            S_DECODE: begin
                state_d = legal ? S_EXEC : S_TRAP;
            end

            S_EXEC: begin
                if (is_auipc || is_jal || is_branch) begin
                    ctrl.alu_a_sel = ALU_A_PC;
                end else if (is_lui) begin
                    ctrl.alu_a_sel = ALU_A_ZERO;
                end else begin
                    ctrl.alu_a_sel = ALU_A_RS1;
                end
                ctrl.alu_b_sel = ~is_op;

                if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_branch) begin
                    // Target was formed by the ALU in this cycle's operands;
                    // the comparator decides between it and PC+4.
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_sel = br_taken_i;
                    state_d     = S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                ctrl.dmem_req = 1'b1;
                ctrl.dmem_we  = is_store;
                if (dmem_ack_i) begin
                    if (is_store) begin
                        // Stores have no writeback, so the PC advances here.
                        ctrl.pc_we = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_expired) begin
                    timeout_entry = 1'b1;
                    state_d       = S_TRAP;
                end
            end

            S_WB: begin
                ctrl.rf_we = 1'b1;
                if (is_load) begin
                    ctrl.wb_sel = WB_MEM;
                end else if (is_jal || is_jalr) begin
                    ctrl.wb_sel = WB_PC4;
                end else begin
                    ctrl.wb_sel = WB_ALU;
                end
                ctrl.pc_we  = 1'b1;
                ctrl.pc_sel = is_jal | is_jalr;
                state_d     = S_FETCH;
            end

            S_TRAP: begin
                // Sink state: only reset leaves it.
                ctrl.illegal = ~trap_by_timeout;
                ctrl.timeout = trap_by_timeout;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: forced low while reset is asserted, independent of the clock
    // -------------------------------------------------------------------------
    ctrl_t ctrl_out;

    assign ctrl_out    = rst_i ? '0 : ctrl;

    assign imem_req_o  = ctrl_out.imem_req;
    assign ir_we_o     = ctrl_out.ir_we;
    assign dmem_req_o  = ctrl_out.dmem_req;
    assign dmem_we_o   = ctrl_out.dmem_we;
    assign pc_we_o     = ctrl_out.pc_we;
    assign pc_sel_o    = ctrl_out.pc_sel;
    assign rf_we_o     = ctrl_out.rf_we;
    assign alu_a_sel_o = ctrl_out.alu_a_sel;
    assign alu_b_sel_o = ctrl_out.alu_b_sel;
    assign wb_sel_o    = ctrl_out.wb_sel;
    assign illegal_o   = ctrl_out.illegal;
    assign timeout_o   = ctrl_out.timeout;
    assign state_o     = rst_i ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each clock cycle the stimulus drives
// the acks/branch flag, pushes the output vector the controller must show in
// that cycle onto a scoreboard queue, and pops/compares it at the falling
// edge. instr_i models the instruction register: it is driven to zero while
// the controller is expected in FETCH so that only the fetched value matters.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int F = 0;
    localparam int D = 1;
    localparam int E = 2;
    localparam int M = 3;
    localparam int W = 4;
    localparam int T = 5;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        imem_req_o;
    logic        imem_ack_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic        dmem_ack_i;
    logic        br_taken_i;
    logic        ir_we_o;
    logic        pc_we_o;
    logic        rf_we_o;
    logic        pc_sel_o;
    logic [1:0]  alu_a_sel_o;
    logic        alu_b_sel_o;
    logic [1:0]  wb_sel_o;
    logic        illegal_o;
    logic        timeout_o;
    logic [2:0]  state_o;

    typedef struct packed {
        logic [2:0] state;
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic       pc_sel;
        logic       rf_we;
        logic [1:0] alu_a;
        logic       alu_b;
        logic [1:0] wb_sel;
        logic       illegal;
        logic       timeout;
    } outs_t;

    typedef struct {
        string tag;
        outs_t v;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] cur_instr;

    multicycle_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .instr_i     (instr_i),
        .imem_req_o  (imem_req_o),
        .imem_ack_i  (imem_ack_i),
        .dmem_req_o  (dmem_req_o),
        .dmem_we_o   (dmem_we_o),
        .dmem_ack_i  (dmem_ack_i),
        .br_taken_i  (br_taken_i),
        .ir_we_o     (ir_we_o),
        .pc_we_o     (pc_we_o),
        .rf_we_o     (rf_we_o),
        .pc_sel_o    (pc_sel_o),
        .alu_a_sel_o (alu_a_sel_o),
        .alu_b_sel_o (alu_b_sel_o),
        .wb_sel_o    (wb_sel_o),
        .illegal_o   (illegal_o),
        .timeout_o   (timeout_o),
        .state_o     (state_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic outs_t observe();
        outs_t o;
        o = '{state_o, imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, pc_we_o,
              pc_sel_o, rf_we_o, alu_a_sel_o, alu_b_sel_o, wb_sel_o,
              illegal_o, timeout_o};
        return o;
    endfunction

    task automatic compare(input string tag, input outs_t expv);
        outs_t obs;
        obs = observe();
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (state obs %0d exp %0d)",
                   tag, obs, expv, obs.state, expv.state);
        end
    endtask

    // One clock cycle: drive inputs, push expectation, compare at negedge.
    task automatic cyc(input string tag, input int ia, input int da, input int bt,
                       input int s, input int ireq, input int irwe, input int dreq,
                       input int dwe, input int pcwe, input int pcsel, input int rfwe,
                       input int aa, input int ab, input int wb, input int ill,
                       input int to);
        exp_t e;
        exp_t got;
        imem_ack_i = ia[0];
        dmem_ack_i = da[0];
        br_taken_i = bt[0];
        instr_i    = (s == F) ? 32'h0 : cur_instr;
        e.tag = tag;
        e.v   = '{s[2:0], ireq[0], irwe[0], dreq[0], dwe[0], pcwe[0], pcsel[0],
                  rfwe[0], aa[1:0], ab[0], wb[1:0], ill[0], to[0]};
        exp_q.push_back(e);
        @(negedge clk_i);
        got = exp_q.pop_front();
        compare(got.tag, got.v);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i      = 1'b1;
        imem_ack_i = 1'b0;
        dmem_ack_i = 1'b0;
        br_taken_i = 1'b0;
        instr_i    = 32'h0;
        cur_instr  = 32'h0;
        @(posedge clk_i);
        #1;

        // Reset held: everything low, acks ignored.
        cyc("rst_hold0", 1,1,1, F, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("rst_hold1", 1,1,1, F, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        rst_i = 1'b0;

        // ADDI x1,x0,5: ack two cycles after the first request.
        cur_instr = 32'h00500093;
        cyc("addi_f0",    0,0,0, F, 1,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("addi_f1",    0,0,0, F, 1,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("addi_f2ack", 1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("addi_dec",   1,1,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("addi_exe",   1,0,0, E, 0,0,0,0,0,0,0, 0,1,0, 0,0);
        cyc("addi_wb",    0,0,0, W, 0,0,0,0,1,0,1, 0,0,0, 0,0);

        // LW: data ack on the third MEM cycle.
        cur_instr = 32'h0000A103;
        cyc("lw_f",       1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("lw_dec",     0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("lw_exe",     0,1,0, E, 0,0,0,0,0,0,0, 0,1,0, 0,0);
        cyc("lw_mem0",    0,0,0, M, 0,0,1,0,0,0,0, 0,0,0, 0,0);
        cyc("lw_mem1",    0,0,0, M, 0,0,1,0,0,0,0, 0,0,0, 0,0);
        cyc("lw_mem2ack", 0,1,0, M, 0,0,1,0,0,0,0, 0,0,0, 0,0);
        cyc("lw_wb",      0,0,0, W, 0,0,0,0,1,0,1, 0,0,1, 0,0);

        // SW: immediate acks, four cycles, PC written in the MEM ack cycle.
        cur_instr = 32'h00112023;
        cyc("sw_f",       1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("sw_dec",     0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("sw_exe",     0,0,0, E, 0,0,0,0,0,0,0, 0,1,0, 0,0);
        cyc("sw_memack",  0,1,0, M, 0,0,1,1,1,0,0, 0,0,0, 0,0);

        // BEQ taken, then not taken.
        cur_instr = 32'h00000463;
        cyc("beqt_f",     1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("beqt_dec",   0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("beqt_exe",   0,0,1, E, 0,0,0,0,1,1,0, 1,1,0, 0,0);
        cyc("beqn_f",     1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("beqn_dec",   0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("beqn_exe",   0,0,0, E, 0,0,0,0,1,0,0, 1,1,0, 0,0);

        // JAL.
        cur_instr = 32'h008000EF;
        cyc("jal_f",      1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("jal_dec",    0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("jal_exe",    0,0,0, E, 0,0,0,0,0,0,0, 1,1,0, 0,0);
        cyc("jal_wb",     0,0,0, W, 0,0,0,0,1,1,1, 0,0,2, 0,0);

        // JALR.
        cur_instr = 32'h000080E7;
        cyc("jalr_f",     1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("jalr_dec",   0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("jalr_exe",   0,0,0, E, 0,0,0,0,0,0,0, 0,1,0, 0,0);
        cyc("jalr_wb",    0,0,0, W, 0,0,0,0,1,1,1, 0,0,2, 0,0);

        // OP (register-register): only case using rs2. Branch flag ignored.
        cur_instr = 32'h002081B3;
        cyc("op_f",       1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("op_dec",     0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("op_exe",     0,0,1, E, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("op_wb",      0,0,1, W, 0,0,0,0,1,0,1, 0,0,0, 0,0);

        // LUI uses the zero operand; AUIPC uses the PC.
        cur_instr = 32'h000012B7;
        cyc("lui_f",      1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("lui_dec",    0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("lui_exe",    0,0,0, E, 0,0,0,0,0,0,0, 2,1,0, 0,0);
        cyc("lui_wb",     0,0,0, W, 0,0,0,0,1,0,1, 0,0,0, 0,0);
        cur_instr = 32'h00000317;
        cyc("auipc_f",    1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("auipc_dec",  0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("auipc_exe",  0,0,0, E, 0,0,0,0,0,0,0, 1,1,0, 0,0);
        cyc("auipc_wb",   0,0,0, W, 0,0,0,0,1,0,1, 0,0,0, 0,0);

        // Asynchronous reset in the middle of a data access.
        cur_instr = 32'h0000A103;
        cyc("abort_f",    1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("abort_dec",  0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("abort_exe",  0,0,0, E, 0,0,0,0,0,0,0, 0,1,0, 0,0);
        cyc("abort_mem",  0,0,0, M, 0,0,1,0,0,0,0, 0,0,0, 0,0);
        #2;
        rst_i = 1'b1;
        #1;
        compare("abort_async_rst", '0);
        @(posedge clk_i);
        #1;
        cyc("abort_hold", 0,1,0, F, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        rst_i = 1'b0;

        // All-zero instruction is illegal: TRAP held for 20 cycles.
        cur_instr = 32'h00000000;
        cyc("ill0_f",     1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("ill0_dec",   0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        for (int i = 0; i < 20; i++) begin
            cyc("ill0_trap", i % 2, (i + 1) % 2, 1, T, 0,0,0,0,0,0,0, 0,0,0, 1,0);
        end
        rst_i = 1'b1;
        cyc("ill0_rst",   0,0,0, F, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        rst_i = 1'b0;

        // Valid opcode but compressed-quadrant low bits: also illegal.
        cur_instr = 32'h00500092;
        cyc("ill1_f",     1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("ill1_dec",   0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        cyc("ill1_trap0", 1,1,0, T, 0,0,0,0,0,0,0, 0,0,0, 1,0);
        cyc("ill1_trap1", 0,0,0, T, 0,0,0,0,0,0,0, 0,0,0, 1,0);
        rst_i = 1'b1;
        cyc("ill1_rst",   0,0,0, F, 0,0,0,0,0,0,0, 0,0,0, 0,0);
        rst_i = 1'b0;

        // Fetch left unacknowledged.
        cur_instr = 32'h00500093;
`ifdef CTRL_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            cyc("to_wait",    0,0,0, F, 1,0,0,0,0,0,0, 0,0,0, 0,0);
        end
        for (int i = 0; i < 3; i++) begin
            cyc("to_trap",    1,1,0, T, 0,0,0,0,0,0,0, 0,0,0, 0,1);
        end
`else
        for (int i = 0; i < 20; i++) begin
            cyc("noto_wait",  0,0,0, F, 1,0,0,0,0,0,0, 0,0,0, 0,0);
        end
        cyc("noto_ack",   1,0,0, F, 1,1,0,0,0,0,0, 0,0,0, 0,0);
        cyc("noto_dec",   0,0,0, D, 0,0,0,0,0,0,0, 0,0,0, 0,0);
`endif

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL sb_drain: observed %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
